// File: rtl/shared_adder_pkg.sv
// Purpose: shared types and sizing helpers for the time-shared nibble adder scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package shared_adder_pkg;

  // Scheduler phases: waiting for a request, stepping nibbles, holding the result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Requester identifier; two requesters share the adder.
  typedef logic req_id_t;
  localparam req_id_t REQ0 = 1'b0;
  localparam req_id_t REQ1 = 1'b1;

  // Number of 4-bit steps needed for a WIDTH-bit operand.
  function automatic int nib_count(input int width);
    return width / 4;
  endfunction

  // Width of the nibble step counter; at least one bit even for a single step.
  function automatic int cnt_width(input int width);
    int n;
    n = width / 4;
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/nibble_adder.sv
// Purpose: combinational 4-bit adder with carry in/out, the datapath shared by both requesters.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; no flow control.
// Ports: a, b (4-bit operands), cin (carry in) -> sum (4-bit), cout (carry out of bit 3).
module nibble_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};

endmodule

// File: rtl/shared_adder_sched.sv
// Purpose: round-robin arbiter that time-shares one nibble adder between two requesters.
// Latency: res_valid rises WIDTH/4 edges after the accepting edge.
// Backpressure: res_ready low holds the result in DONE; both req readys stay low until it drains.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   reqN_valid/_ready/_a/_b/_cin     requester N handshake, operands and carry-in (N = 0, 1)
//   res_valid/_ready                 result handshake
//   res_sum, res_cout, res_id        a + b + cin split as {cout, sum}, and the issuing requester
// WIDTH must be a multiple of 4 and at least 4.
module shared_adder_sched #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_cout,
  output logic             res_id
);

  import shared_adder_pkg::*;

  localparam int NIB = nib_count(WIDTH);
  localparam int CW  = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(NIB - 1);

  state_t           state;
  req_id_t          prio;
  req_id_t          win;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             grant_ok;
  logic             accept;
  logic [3:0]       nib_sum;
  logic             nib_cout;
  logic [WIDTH-1:0] sum_nxt;

  // Winner: a lone valid wins outright; on contention the priority pointer decides.
  always_comb begin
    win = REQ0;
    if (req0_valid && req1_valid) begin
      win = prio;
    end else if (req1_valid) begin
      win = REQ1;
    end
  end

  // Grants are only offered while idle and out of reset.
  assign grant_ok   = (state == IDLE) && !rst;
  assign req0_ready = grant_ok && req0_valid && (win == REQ0);
  assign req1_ready = grant_ok && req1_valid && (win == REQ1);
  assign accept     = req0_ready || req1_ready;

  nibble_adder u_nibble_adder (
    .a    (a_reg[3:0]),
    .b    (b_reg[3:0]),
    .cin  (carry),
    .sum  (nib_sum),
    .cout (nib_cout)
  );

  // Each new nibble enters at the MSB end; after NIB steps the LSB nibble has
  // walked down to bits [3:0].
  generate
    if (WIDTH > 4) begin : g_shift
      assign sum_nxt = {nib_sum, res_sum[WIDTH-1:4]};
    end else begin : g_single
      assign sum_nxt = nib_sum;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      prio      <= REQ0;
      res_valid <= 1'b0;
      res_sum   <= '0;
      res_cout  <= 1'b0;
      res_id    <= REQ0;
      carry     <= 1'b0;
      cnt       <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_reg  <= (win == REQ1) ? req1_a   : req0_a;
            b_reg  <= (win == REQ1) ? req1_b   : req0_b;
            carry  <= (win == REQ1) ? req1_cin : req0_cin;
            res_id <= win;
            cnt    <= '0;
            prio   <= ~win;
            state  <= RUN;
          end
        end
        RUN: begin
          res_sum <= sum_nxt;
          carry   <= nib_cout;
          a_reg   <= a_reg >> 4;
          b_reg   <= b_reg >> 4;
          cnt     <= cnt + 1'b1;
          if (cnt == LAST) begin
            res_cout  <= nib_cout;
            res_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          // No accept here even on the handshake edge; IDLE is always visited first.
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shared_adder_sched.sv
// Purpose: directed and random checks of the shared nibble-adder scheduler at WIDTH=16.
// Latency: n/a (testbench).
// Backpressure: drives res_ready low for variable stretches to exercise DONE holding.
module tb_shared_adder_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req0_cin;
  logic [15:0] req0_a, req0_b;
  logic        req1_valid, req1_ready, req1_cin;
  logic [15:0] req1_a, req1_b;
  logic        res_valid, res_ready, res_cout, res_id;
  logic [15:0] res_sum;

  int   n_vec = 0;
  int   n_err = 0;
  logic m_prio = 1'b0;

  always #5 clk = ~clk;

  shared_adder_sched #(.WIDTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_cin   (req0_cin),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_cin   (req1_cin),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_sum    (res_sum),
    .res_cout   (res_cout),
    .res_id     (res_id)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // All tasks are entered and left 1 time unit after a rising edge.
  task automatic do_reset();
    rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    m_prio = 1'b0;
  endtask

  // Present one or two requests, check the grant against the round-robin model,
  // take the accepting edge, then scramble the operand buses.
  task automatic issue(input bit v0, input bit v1,
                       input logic [15:0] a0, input logic [15:0] b0, input logic c0,
                       input logic [15:0] a1, input logic [15:0] b1, input logic c1,
                       output logic wid);
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_cin = c0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_cin = c1;
    #1;
    wid = (v0 && v1) ? m_prio : (v1 ? 1'b1 : 1'b0);
    chk("grant0", req0_ready, v0 && (wid == 1'b0));
    chk("grant1", req1_ready, v1 && (wid == 1'b1));
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = 16'($urandom); req0_b = 16'($urandom); req0_cin = 1'($urandom);
    req1_a = 16'($urandom); req1_b = 16'($urandom); req1_cin = 1'($urandom);
    m_prio = ~wid;
  endtask

  // Wait (bounded) for the result, check latency and value, hold it, then drain it.
  task automatic collect(input logic [15:0] es, input logic ec, input logic eid,
                         input int hold, input bit rnd_rdy);
    int n = 0;
    while (!res_valid && n < 20) begin
      res_ready = rnd_rdy ? 1'($urandom) : 1'b0;
      @(posedge clk); #1;
      n++;
    end
    res_ready = 1'b0;
    chk("latency", n, 4);
    chk("sum", res_sum, es);
    chk("cout", res_cout, ec);
    chk("id", res_id, eid);
    repeat (hold) begin
      @(posedge clk); #1;
      chk("hold_valid", res_valid, 1);
      chk("hold_sum", res_sum, es);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk("drained", res_valid, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        wid;
    logic [16:0] ref_sum;
    int          gid[8];
    int          gcyc[8];
    int          ng;
    bit          v0, v1;
    logic [15:0] a0, b0, a1, b1;
    logic        c0, c1;

    rst = 1'b1; res_ready = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = '0; req0_b = '0; req0_cin = 1'b0;
    req1_a = '0; req1_b = '0; req1_cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", res_valid, 0);
    chk("rst_sum", res_sum, 0);
    chk("rst_cout", res_cout, 0);
    chk("rst_id", res_id, 0);
    chk("rst_ready0", req0_ready, 0);
    chk("rst_ready1", req1_ready, 0);
    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1;

    // Basic add from requester 0.
    issue(1, 0, 16'h1234, 16'h0FCD, 1'b0, 16'h0, 16'h0, 1'b0, wid);
    collect(16'h2201, 1'b0, 1'b0, 2, 0);

    // Inter-nibble carry and full carry-out from requester 1.
    issue(0, 1, 16'h0, 16'h0, 1'b0, 16'h0FFF, 16'h0001, 1'b0, wid);
    collect(16'h1000, 1'b0, 1'b1, 0, 0);
    issue(0, 1, 16'h0, 16'h0, 1'b0, 16'hFFFF, 16'h0000, 1'b1, wid);
    collect(16'h0000, 1'b1, 1'b1, 0, 0);

    // Continuous contention: grants alternate, one IDLE cycle every NIB+2.
    do_reset();
    for (int i = 0; i < 8; i++) begin gid[i] = -1; gcyc[i] = -1; end
    ng = 0;
    res_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 16'h0001; req0_b = 16'h0001; req0_cin = 1'b0;
    req1_valid = 1'b1; req1_a = 16'h0002; req1_b = 16'h0002; req1_cin = 1'b0;
    for (int c = 0; c < 40; c++) begin
      #1;
      chk("rr_onehot", req0_ready && req1_ready, 0);
      if (req0_ready || req1_ready) begin
        if (ng < 8) begin gid[ng] = req1_ready ? 1 : 0; gcyc[ng] = c; end
        ng++;
      end
      @(posedge clk); #1;
    end
    chk("rr_count", ng >= 4, 1);
    for (int i = 0; i < 4; i++) chk("rr_order", gid[i], i % 2);
    for (int i = 1; i < 4; i++) chk("rr_spacing", gcyc[i] - gcyc[i-1], 6);

    // Backpressure: result held 10 cycles with both requesters waiting.
    do_reset();
    req0_valid = 1'b1; req0_a = 16'h8000; req0_b = 16'h8001; req0_cin = 1'b1;
    #1;
    chk("bp_grant", req0_ready, 1);
    @(posedge clk); #1;
    req1_valid = 1'b1; req0_a = 16'h5555; req0_b = 16'h1111;
    m_prio = 1'b1;
    begin
      int n = 0;
      while (!res_valid && n < 20) begin
        chk("bp_run_ready", req0_ready || req1_ready, 0);
        @(posedge clk); #1;
        n++;
      end
      chk("bp_latency", n, 4);
    end
    repeat (10) begin
      @(posedge clk); #1;
      chk("bp_sum", res_sum, 16'h0002);
      chk("bp_cout", res_cout, 1);
      chk("bp_id", res_id, 0);
      chk("bp_readys", {req0_ready, req1_ready}, 0);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk("bp_idle_valid", res_valid, 0);
    chk("bp_idle_ready1", req1_ready, 1);
    chk("bp_idle_ready0", req0_ready, 0);
    #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1;

    // Reset on the second RUN edge loses the result and restores prio to requester 0.
    issue(1, 0, 16'h1111, 16'h2222, 1'b0, 16'h0, 16'h0, 1'b0, wid);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_prio = 1'b0;
    chk("abort_valid", res_valid, 0);
    chk("abort_sum", res_sum, 0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("abort_prio0", req0_ready, 1);
    chk("abort_prio1", req1_ready, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      chk("abort_lost", res_valid, 0);
    end
    issue(1, 0, 16'h00FF, 16'h0001, 1'b0, 16'h0, 16'h0, 1'b0, wid);
    collect(16'h0100, 1'b0, 1'b0, 0, 0);

    // Random traffic from both requesters with random result backpressure.
    for (int k = 0; k < 1000; k++) begin
      v0 = 1'($urandom); v1 = 1'($urandom);
      if (!v0 && !v1) v0 = 1'b1;
      a0 = 16'($urandom); b0 = 16'($urandom); c0 = 1'($urandom);
      a1 = 16'($urandom); b1 = 16'($urandom); c1 = 1'($urandom);
      issue(v0, v1, a0, b0, c0, a1, b1, c1, wid);
      ref_sum = wid ? ({1'b0, a1} + {1'b0, b1} + {16'h0, c1})
                    : ({1'b0, a0} + {1'b0, b0} + {16'h0, c0});
      collect(ref_sum[15:0], ref_sum[16], wid, $urandom_range(0, 2), 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
